ct_fcnvt_htod_norm: RTL

Two-stage pipelined half-to-double converter for the vector/scalar FP convert path. It takes a 16-bit IEEE half operand, classifies it, and normalises half subnormals into double normals using a leading-zero count and left shift. It packs a 64-bit double and RISC-V fflags. It sits beside the double-to-half subnormal shifter and is the widening counterpart to that narrowing path, with valid/ready handshakes on both sides.

---
 rtl/ct_fcnvt_htod_norm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ct_fcnvt_htod_norm.sv
// ct_fcnvt_htod_norm: two-stage half-to-double converter with valid/ready.
// S1 classifies the half operand and counts leading zeros of the fraction;
// S2 packs the double result and fflags. Half subnormals become double
// normals, so the conversion is always exact.
// Optional feature macro: FCNVT_HTOD_NAN_PROP_EN (NaN payload propagation;
// without it every NaN returns the canonical double NaN).
module ct_fcnvt_htod_norm #(
  parameter int TAG_W = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             htod_in_vld,
  output logic             htod_in_rdy,
  input  logic [15:0]      htod_in_src,
  input  logic [TAG_W-1:0] htod_in_tag,
  output logic             htod_out_vld,
  input  logic             htod_out_rdy,
  output logic [63:0]      htod_out_result,
  output logic [4:0]       htod_out_fflags,
  output logic [TAG_W-1:0] htod_out_tag
);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } cls_e;

  // Leading-zero count of a 10-bit fraction; only meaningful when nonzero.
  function automatic logic [3:0] lzc10(input logic [9:0] f);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1'b1;
        else      n     = n + 4'd1;
      end
    end
    return n;
  endfunction

  // Stage state
  logic             s1_vld_q;
  logic             s1_sign_q;
  cls_e             s1_cls_q;
  logic [4:0]       s1_exp_q;
  logic [9:0]       s1_frac_q;
  logic [3:0]       s1_lz_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_vld_q;
  logic [63:0]      s2_result_q;
  logic [4:0]       s2_fflags_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Next-state values
  cls_e             s1_cls_d;
  logic [3:0]       s1_lz_d;
  logic [63:0]      s2_result_d;
  logic [4:0]       s2_fflags_d;
  logic [9:0]       sub_sh;

  logic s1_en;
  logic s2_en;

  // A stage may load when it is empty or its contents move on this cycle.
  // The ready path is combinational from htod_out_rdy so a full pipeline
  // still accepts one operand per cycle while draining.
  assign s2_en        = !s2_vld_q | htod_out_rdy;
  assign s1_en        = !s1_vld_q | s2_en;
  assign htod_in_rdy  = s1_en & !cpurst;
  assign htod_out_vld = s2_vld_q & !cpurst;

  assign htod_out_result = s2_result_q;
  assign htod_out_fflags = s2_fflags_q;
  assign htod_out_tag    = s2_tag_q;

  // Classify the incoming half operand and count fraction leading zeros.
  always_comb begin
    s1_cls_d = CLS_NORM;
    s1_lz_d  = lzc10(htod_in_src[9:0]);
    if (htod_in_src[14:10] == 5'd0) begin
      s1_cls_d = (htod_in_src[9:0] == 10'd0) ? CLS_ZERO : CLS_SUB;
    end else if (htod_in_src[14:10] == 5'd31) begin
      if (htod_in_src[9:0] == 10'd0) s1_cls_d = CLS_INF;
      else if (htod_in_src[9])       s1_cls_d = CLS_QNAN;
      else                           s1_cls_d = CLS_SNAN;
    end
  end

  // S1 register: capture classified operand on an input transfer.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= CLS_ZERO;
      s1_exp_q  <= 5'd0;
      s1_frac_q <= 10'd0;
      s1_lz_q   <= 4'd0;
      s1_tag_q  <= '0;
    end else if (s1_en) begin
      s1_vld_q <= htod_in_vld;
      if (htod_in_vld) begin
        s1_sign_q <= htod_in_src[15];
        s1_cls_q  <= s1_cls_d;
        s1_exp_q  <= htod_in_src[14:10];
        s1_frac_q <= htod_in_src[9:0];
        s1_lz_q   <= s1_lz_d;
        s1_tag_q  <= htod_in_tag;
      end
    end
  end

  // Pack the double result and flags from the S1 classification.
  always_comb begin
    s2_result_d = 64'h0;
    s2_fflags_d = 5'h0;
    // Shift the leading one to bit 9; the bits below it form the fraction
    // once the implicit one is dropped.
    sub_sh      = s1_frac_q << s1_lz_q;
    case (s1_cls_q)
      CLS_ZERO: s2_result_d = {s1_sign_q, 63'h0};
      CLS_SUB:  s2_result_d = {s1_sign_q, 11'd1008 - {7'h0, s1_lz_q},
                               sub_sh[8:0], 1'b0, 42'h0};
      CLS_NORM: s2_result_d = {s1_sign_q, {6'h0, s1_exp_q} + 11'd1008,
                               s1_frac_q, 42'h0};
      CLS_INF:  s2_result_d = {s1_sign_q, 11'h7FF, 52'h0};
      CLS_QNAN, CLS_SNAN: begin
`ifdef FCNVT_HTOD_NAN_PROP_EN
        // Keep sign and payload; force the quiet bit so sNaNs are quieted.
        s2_result_d = {s1_sign_q, 11'h7FF, 1'b1, s1_frac_q[8:0], 42'h0};
`else
        s2_result_d = 64'h7FF8_0000_0000_0000;
`endif
      end
      default:  s2_result_d = 64'h0;
    endcase
    s2_fflags_d[4] = (s1_cls_q == CLS_SNAN);
  end

  // S2 register: holds the output stable while downstream stalls.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s2_vld_q    <= 1'b0;
      s2_result_q <= 64'h0;
      s2_fflags_q <= 5'h0;
      s2_tag_q    <= '0;
    end else if (s2_en) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_result_q <= s2_result_d;
        s2_fflags_q <= s2_fflags_d;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

endmodule
